// File: rtl/oled_page_sched.sv
// oled_page_sched: PmodOLED frame-refresh sequencer driving SpiCtrl from a PAGES x COLS frame buffer.
// Define OLED_SCHED_CONT_EN for continuous refresh while INIT_DONE stays high.
module oled_page_sched #(
    parameter int PAGES  = 4,
    parameter int COLS   = 128,
    parameter int PAGE_W = 2,
    parameter int COL_W  = 7
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic                    INIT_DONE,
    output logic                    BUSY,
    output logic                    DONE,
    output logic [PAGE_W+COL_W-1:0] BUF_ADDR,
    input  logic [7:0]              BUF_DATA,
    output logic                    SPI_EN,
    output logic [7:0]              SPI_DATA,
    input  logic                    SPI_FIN,
    output logic                    DC
);
    typedef enum logic [2:0] {IDLE, CMD, FETCH, LOAD, SEND, WAIT, CLR, DONE_ST} state_t;
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(PAGES - 1);
`ifdef OLED_SCHED_CONT_EN
    localparam logic CONT = 1'b1;
`else
    localparam logic CONT = 1'b0;
`endif
    state_t state, nxt;
    logic [PAGE_W-1:0] page;
    logic [COL_W-1:0]  col;
    logic [1:0]        cmd_idx;
    logic              cont_go;
    assign cont_go = CONT & INIT_DONE;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= nxt;
    end
    // DC doubles as the phase flag: low while sending the three address commands
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (START && INIT_DONE) ? CMD : IDLE;
            CMD:     nxt = SEND;
            FETCH:   nxt = LOAD;
            LOAD:    nxt = SEND;
            SEND:    nxt = WAIT;
            WAIT:    nxt = SPI_FIN ? CLR : WAIT;
            CLR:     nxt = SPI_FIN ? CLR :
                           !DC ? (cmd_idx == 2'd2 ? FETCH : CMD) :
                           col != COL_LAST ? FETCH :
                           page != PAGE_LAST ? CMD : DONE_ST;
            DONE_ST: nxt = cont_go ? CMD : IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_comb begin
        DONE = state == DONE_ST;
        BUSY = state != IDLE && !(state == DONE_ST && !cont_go);
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            SPI_EN   <= 1'b0;
            SPI_DATA <= 8'h00;
            DC       <= 1'b0;
            BUF_ADDR <= '0;
            page     <= '0;
            col      <= '0;
            cmd_idx  <= '0;
        end else begin
            case (state)
                IDLE: if (START && INIT_DONE) begin
                    page    <= '0;
                    col     <= '0;
                    cmd_idx <= '0;
                end
                CMD: begin
                    DC       <= 1'b0;
                    SPI_DATA <= cmd_idx == 2'd0 ? (8'hB0 | 8'(page)) : cmd_idx == 2'd1 ? 8'h00 : 8'h10;
                end
                FETCH: BUF_ADDR <= {page, col};
                LOAD: begin
                    SPI_DATA <= BUF_DATA;
                    DC       <= 1'b1;
                end
                SEND: SPI_EN <= 1'b1;
                WAIT: if (SPI_FIN) SPI_EN <= 1'b0;
                CLR: if (!SPI_FIN) begin
                    if (!DC) begin
                        cmd_idx <= cmd_idx == 2'd2 ? 2'd0 : cmd_idx + 2'd1;
                        col     <= '0;
                    end else if (col != COL_LAST) begin
                        col <= col + 1'b1;
                    end else begin
                        col  <= '0;
                        page <= page == PAGE_LAST ? '0 : page + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_oled_page_sched.sv
// tb_oled_page_sched: scoreboard bench for oled_page_sched with SpiCtrl and frame-RAM models.
module tb_oled_page_sched;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, init_done = 1'b0;
    logic       busy, done, spi_en, spi_fin, dc;
    logic [8:0] buf_addr;
    logic [7:0] buf_data, spi_data;
    logic [2:0] fin_cnt;
    logic       en_prev = 1'b0, done_prev = 1'b0;
    logic [8:0] exp_q[$];
    int         total = 0, bad = 0, nbytes = 0, dones = 0;
    int         b0, d0;

    oled_page_sched dut (
        .CLK(clk), .RST(rst), .START(start), .INIT_DONE(init_done),
        .BUSY(busy), .DONE(done), .BUF_ADDR(buf_addr), .BUF_DATA(buf_data),
        .SPI_EN(spi_en), .SPI_DATA(spi_data), .SPI_FIN(spi_fin), .DC(dc)
    );

    always #5 clk = ~clk;
    assign buf_data = buf_addr[7:0];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_fin <= 1'b0;
            fin_cnt <= '0;
        end else if (!spi_en) begin
            spi_fin <= 1'b0;
            fin_cnt <= '0;
        end else begin
            fin_cnt <= fin_cnt + 3'd1;
            if (fin_cnt == 3'd3) spi_fin <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int n);
        int k = 0;
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 3; c++) begin
                if (k < n) exp_q.push_back({1'b0, c == 0 ? 8'(8'hB0 | p) : c == 1 ? 8'h00 : 8'h10});
                k++;
            end
            for (int c = 0; c < 128; c++) begin
                if (k < n) exp_q.push_back({1'b1, 8'((p * 128 + c) & 255)});
                k++;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 20000 && dones < target; i++) @(negedge clk);
        check("done_seen", dones >= target, 1);
    endtask

    always @(negedge clk) begin
        if (spi_en && !en_prev) begin
            nbytes++;
            check("queue_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("byte", {dc, spi_data}, exp_q.pop_front());
        end
        if (done) begin
            dones++;
            check("done_width", done_prev, 0);
`ifndef OLED_SCHED_CONT_EN
            check("busy_at_done", busy, 0);
`endif
        end
        en_prev = spi_en;
        done_prev = done;
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_spi_en", spi_en, 0);
        check("rst_dc", dc, 0);
        check("rst_addr", buf_addr, 0);
        check("rst_edges", nbytes, 0);

        pulse_start();
        repeat (100) @(negedge clk);
        check("noinit_busy", busy, 0);
        check("noinit_bytes", nbytes, 0);
        init_done = 1'b1;
        repeat (20) @(negedge clk);
        check("nostart_busy", busy, 0);
        check("nostart_bytes", nbytes, 0);

`ifndef OLED_SCHED_CONT_EN
        b0 = nbytes; d0 = dones;
        push_frame(524);
        pulse_start();
        check("busy_after_start", busy, 1);
        wait_done(d0 + 1);
        repeat (5) @(negedge clk);
        check("frame_bytes", nbytes - b0, 524);
        check("frame_dones", dones - d0, 1);
        check("busy_idle", busy, 0);

        b0 = nbytes; d0 = dones;
        push_frame(524);
        pulse_start();
        for (int i = 0; i < 400 && dones == d0; i++) begin
            repeat (50) @(negedge clk);
            if (busy) pulse_start();
        end
        repeat (20) @(negedge clk);
        check("spam_bytes", nbytes - b0, 524);
        check("spam_dones", dones - d0, 1);
        b0 = nbytes; d0 = dones;
        push_frame(524);
        pulse_start();
        wait_done(d0 + 1);
        repeat (5) @(negedge clk);
        check("second_bytes", nbytes - b0, 524);

        b0 = nbytes;
        push_frame(44);
        pulse_start();
        for (int i = 0; i < 5000 && !(nbytes - b0 == 44 && spi_en); i++) @(negedge clk);
        check("reach_byte40", nbytes - b0, 44);
        #2 rst = 1'b1;
        #1;
        check("arst_spi_en", spi_en, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        check("arst_queue", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        b0 = nbytes; d0 = dones;
        push_frame(524);
        pulse_start();
        wait_done(d0 + 1);
        repeat (5) @(negedge clk);
        check("post_rst_bytes", nbytes - b0, 524);
`else
        b0 = nbytes; d0 = dones;
        push_frame(524);
        push_frame(524);
        pulse_start();
        wait_done(d0 + 1);
        check("cont_busy", busy, 1);
        for (int i = 0; i < 5000 && nbytes - b0 < 624; i++) @(negedge clk);
        init_done = 1'b0;
        wait_done(d0 + 2);
        repeat (20) @(negedge clk);
        check("cont_busy_end", busy, 0);
        check("cont_bytes", nbytes - b0, 1048);
        check("cont_dones", dones - d0, 2);
`endif
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
